// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg
//   Shared pipeline definitions for the write-back stage: data-source select
//   encodings and default datapath/register-index widths.
package wb_regfile_pkg;

  localparam int unsigned PKG_DATA_WIDTH = 32;
  localparam int unsigned PKG_ADDR_WIDTH = 5;

  // Write-back data source. Code 2'b11 is not named and falls back to ALU.
  typedef enum logic [1:0] {
    DBSRC_ALU = 2'b00,
    DBSRC_MEM = 2'b01,
    DBSRC_PC4 = 2'b10
  } dbsrc_e;

endpackage

// File: rtl/wb_regfile_if.sv
// wb_regfile_if
//   MEM/WB-to-register-file bus plus the two ID-stage read ports.
//   master : pipeline side (drives WB_* controls/data and ID_rs/ID_rt)
//   slave  : register file (returns ID_ReadData1/2 and WB_WriteData)
interface wb_regfile_if
  import wb_regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PKG_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = PKG_ADDR_WIDTH
);
  logic [1:0]            WB_DBDataSrc;
  logic                  WB_RegWre;
  logic [DATA_WIDTH-1:0] WB_PCadd4;
  logic [DATA_WIDTH-1:0] WB_DataFromMemory;
  logic [DATA_WIDTH-1:0] WB_DataFromALU;
  logic [ADDR_WIDTH-1:0] WB_WriteReg;
  logic [ADDR_WIDTH-1:0] ID_rs;
  logic [ADDR_WIDTH-1:0] ID_rt;
  logic [DATA_WIDTH-1:0] ID_ReadData1;
  logic [DATA_WIDTH-1:0] ID_ReadData2;
  logic [DATA_WIDTH-1:0] WB_WriteData;

  modport master (
    output WB_DBDataSrc, WB_RegWre, WB_PCadd4, WB_DataFromMemory,
           WB_DataFromALU, WB_WriteReg, ID_rs, ID_rt,
    input  ID_ReadData1, ID_ReadData2, WB_WriteData
  );

  modport slave (
    input  WB_DBDataSrc, WB_RegWre, WB_PCadd4, WB_DataFromMemory,
           WB_DataFromALU, WB_WriteReg, ID_rs, ID_rt,
    output ID_ReadData1, ID_ReadData2, WB_WriteData
  );
endinterface

// File: rtl/wb_regfile_reg_array.sv
// reg_array
//   2^ADDR_WIDTH x DATA_WIDTH storage, asynchronously cleared, one write port
//   committed on the rising clock edge and two raw combinational read ports.
//   No r0 masking or bypass here; that lives in the top level.
//   Ports: Clk, Reset (async, active-high), we/waddr/wdata write port,
//          raddr1/rdata1 and raddr2/rdata2 read ports.
module reg_array
  import wb_regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PKG_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = PKG_ADDR_WIDTH
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  output logic [DATA_WIDTH-1:0] rdata1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata2
);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile
//   Write-back stage and general-purpose register file. Selects the
//   write-back value (ALU / memory / PC+4), commits it on the rising edge,
//   and serves two combinational ID read ports with same-cycle bypass.
//   Ports: Clk, Reset (async, active-high, clears every register),
//          bus (wb_regfile_if.slave) carrying the WB_* and ID_* signals.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PKG_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = PKG_ADDR_WIDTH
) (
  input  logic         Clk,
  input  logic         Reset,
  wb_regfile_if.slave  bus
);
  logic [DATA_WIDTH-1:0] wb_data;
  logic [DATA_WIDTH-1:0] raw1;
  logic [DATA_WIDTH-1:0] raw2;
  logic                  wr_en;
  logic                  bypass1;
  logic                  bypass2;

  always_comb begin
    wb_data = bus.WB_DataFromALU;
    case (bus.WB_DBDataSrc)
      DBSRC_MEM: wb_data = bus.WB_DataFromMemory;
      DBSRC_PC4: wb_data = bus.WB_PCadd4;
      default:   wb_data = bus.WB_DataFromALU;
    endcase
  end

  assign bus.WB_WriteData = wb_data;

  // Writes to r0 are dropped here so the stored r0 stays zero.
  assign wr_en = bus.WB_RegWre && (bus.WB_WriteReg != '0);

  reg_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_reg_array (
    .Clk    (Clk),
    .Reset  (Reset),
    .we     (wr_en),
    .waddr  (bus.WB_WriteReg),
    .wdata  (wb_data),
    .raddr1 (bus.ID_rs),
    .rdata1 (raw1),
    .raddr2 (bus.ID_rt),
    .rdata2 (raw2)
  );

  // wr_en already excludes index 0, so bypass never fires for r0.
  assign bypass1 = wr_en && (bus.ID_rs == bus.WB_WriteReg);
  assign bypass2 = wr_en && (bus.ID_rt == bus.WB_WriteReg);

  always_comb begin
    bus.ID_ReadData1 = raw1;
    bus.ID_ReadData2 = raw2;
    if (bypass1) bus.ID_ReadData1 = wb_data;
    if (bypass2) bus.ID_ReadData2 = wb_data;
    if (Reset || bus.ID_rs == '0) bus.ID_ReadData1 = '0;
    if (Reset || bus.ID_rt == '0) bus.ID_ReadData2 = '0;
  end

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  logic Clk;
  logic Reset;

  wb_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  wb_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  src;
    logic        wre;
    logic [31:0] pc4;
    logic [31:0] mem;
    logic [31:0] alu;
    logic [4:0]  wreg;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] exp1;
    logic [31:0] exp2;
    logic [31:0] expwd;
  } vec_t;

  vec_t vecs [15];

  task automatic drive(input logic [1:0] src, input logic wre, input logic [31:0] pc4,
                       input logic [31:0] mem, input logic [31:0] alu, input logic [4:0] wreg,
                       input logic [4:0] rs, input logic [4:0] rt);
    bus.WB_DBDataSrc      = src;
    bus.WB_RegWre         = wre;
    bus.WB_PCadd4         = pc4;
    bus.WB_DataFromMemory = mem;
    bus.WB_DataFromALU    = alu;
    bus.WB_WriteReg       = wreg;
    bus.ID_rs             = rs;
    bus.ID_rt             = rt;
  endtask

  initial begin
    //                 src    wre pc4           mem           alu           wreg rs  rt  exp1          exp2          expwd
    vecs[0]  = '{2'b00, 1'b1, 32'h0000_BBBB, 32'h0000_AAAA, 32'hDEAD_BEEF, 5'd8,  5'd8,  5'd0,  32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF};
    vecs[1]  = '{2'b00, 1'b0, 32'h0000_BBBB, 32'h0000_AAAA, 32'h0000_0001, 5'd8,  5'd8,  5'd8,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0001};
    vecs[2]  = '{2'b01, 1'b1, 32'h0000_0333, 32'h0000_00FF, 32'h0000_0777, 5'd9,  5'd9,  5'd8,  32'h0000_00FF, 32'hDEAD_BEEF, 32'h0000_00FF};
    vecs[3]  = '{2'b10, 1'b1, 32'h0040_0008, 32'h0000_0444, 32'h0000_0555, 5'd31, 5'd31, 5'd9,  32'h0040_0008, 32'h0000_00FF, 32'h0040_0008};
    vecs[4]  = '{2'b11, 1'b1, 32'h0000_0666, 32'h0000_0888, 32'h0000_0055, 5'd12, 5'd12, 5'd31, 32'h0000_0055, 32'h0040_0008, 32'h0000_0055};
    vecs[5]  = '{2'b00, 1'b0, 32'h0,         32'h0,         32'h0,         5'd12, 5'd12, 5'd9,  32'h0000_0055, 32'h0000_00FF, 32'h0};
    vecs[6]  = '{2'b00, 1'b1, 32'h0,         32'h0,         32'h0000_0011, 5'd10, 5'd10, 5'd8,  32'h0000_0011, 32'hDEAD_BEEF, 32'h0000_0011};
    vecs[7]  = '{2'b00, 1'b1, 32'h0,         32'h0,         32'h0000_0022, 5'd10, 5'd10, 5'd10, 32'h0000_0022, 32'h0000_0022, 32'h0000_0022};
    vecs[8]  = '{2'b00, 1'b0, 32'h0,         32'h0,         32'h0000_0099, 5'd10, 5'd10, 5'd10, 32'h0000_0022, 32'h0000_0022, 32'h0000_0099};
    vecs[9]  = '{2'b00, 1'b1, 32'h0,         32'h0,         32'hFFFF_FFFF, 5'd0,  5'd0,  5'd0,  32'h0,         32'h0,         32'hFFFF_FFFF};
    vecs[10] = '{2'b00, 1'b0, 32'h0,         32'h0,         32'h0,         5'd0,  5'd0,  5'd0,  32'h0,         32'h0,         32'h0};
    vecs[11] = '{2'b00, 1'b1, 32'h0,         32'h0,         32'h0000_0001, 5'd1,  5'd1,  5'd2,  32'h0000_0001, 32'h0,         32'h0000_0001};
    vecs[12] = '{2'b00, 1'b1, 32'h0,         32'h0,         32'h0000_0002, 5'd2,  5'd1,  5'd2,  32'h0000_0001, 32'h0000_0002, 32'h0000_0002};
    vecs[13] = '{2'b00, 1'b1, 32'h0,         32'h0,         32'h0000_0003, 5'd3,  5'd1,  5'd2,  32'h0000_0001, 32'h0000_0002, 32'h0000_0003};
    vecs[14] = '{2'b00, 1'b0, 32'h0,         32'h0,         32'h0,         5'd3,  5'd3,  5'd2,  32'h0000_0003, 32'h0000_0002, 32'h0};

    Reset = 1'b1;
    drive(2'b00, 1'b0, '0, '0, '0, 5'd0, 5'd0, 5'd0);

    // Reset held: every index reads zero on both ports.
    @(negedge Clk);
    for (int i = 0; i < 32; i++) begin
      bus.ID_rs = 5'(i);
      bus.ID_rt = 5'(31 - i);
      #1;
      check($sformatf("reset_rd1_r%0d", i), bus.ID_ReadData1, 32'h0);
      check($sformatf("reset_rd2_r%0d", 31 - i), bus.ID_ReadData2, 32'h0);
    end

    // A write presented during reset is neither bypassed nor stored.
    drive(2'b00, 1'b1, '0, '0, 32'h0000_ABCD, 5'd7, 5'd7, 5'd7);
    #1;
    check("reset_nobypass_rd1", bus.ID_ReadData1, 32'h0);
    check("reset_nobypass_rd2", bus.ID_ReadData2, 32'h0);
    check("reset_wd_follows", bus.WB_WriteData, 32'h0000_ABCD);
    @(posedge Clk); #1;
    check("reset_write_lost", bus.ID_ReadData1, 32'h0);

    // Release on the falling edge; inputs change there too.
    @(negedge Clk);
    Reset = 1'b0;
    drive(2'b00, 1'b0, '0, '0, '0, 5'd0, 5'd7, 5'd7);
    #1;
    check("post_reset_r7", bus.ID_ReadData1, 32'h0);

    // Table-driven sequence, one vector per cycle, checked before the
    // rising edge so same-cycle bypass is observed.
    for (int i = 0; i < 15; i++) begin
      @(negedge Clk);
      drive(vecs[i].src, vecs[i].wre, vecs[i].pc4, vecs[i].mem, vecs[i].alu,
            vecs[i].wreg, vecs[i].rs, vecs[i].rt);
      #2;
      check($sformatf("v%0d_rd1", i), bus.ID_ReadData1, vecs[i].exp1);
      check($sformatf("v%0d_rd2", i), bus.ID_ReadData2, vecs[i].exp2);
      check($sformatf("v%0d_wd", i), bus.WB_WriteData, vecs[i].expwd);
    end

    // Bypassed value also committed: check r10 after its edge with a write elsewhere.
    @(negedge Clk);
    drive(2'b00, 1'b1, '0, '0, 32'h0000_0BAD, 5'd20, 5'd10, 5'd20);
    #1;
    check("r10_after_edge", bus.ID_ReadData1, 32'h0000_0022);
    check("r20_bypass_other", bus.ID_ReadData2, 32'h0000_0BAD);

    // Mid-run reset: r5=0x1234, then assert Reset between edges.
    @(negedge Clk);
    drive(2'b00, 1'b1, '0, '0, 32'h0000_1234, 5'd5, 5'd5, 5'd8);
    @(posedge Clk); #1;
    drive(2'b00, 1'b0, '0, '0, '0, 5'd5, 5'd5, 5'd8);
    #1;
    check("r5_stored", bus.ID_ReadData1, 32'h0000_1234);
    check("r8_stored", bus.ID_ReadData2, 32'hDEAD_BEEF);
    Reset = 1'b1;
    #1;
    check("r5_async_clear", bus.ID_ReadData1, 32'h0);
    check("r8_async_clear", bus.ID_ReadData2, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    drive(2'b00, 1'b0, '0, '0, '0, 5'd0, 5'd5, 5'd31);
    #1;
    check("r5_after_release", bus.ID_ReadData1, 32'h0);
    check("r31_after_release", bus.ID_ReadData2, 32'h0);

    // First rising edge with Reset low accepts a write.
    drive(2'b10, 1'b1, 32'h0000_0066, 32'h0000_0077, 32'h0000_0088, 5'd6, 5'd0, 5'd0);
    @(posedge Clk); #1;
    drive(2'b00, 1'b0, '0, '0, '0, 5'd6, 5'd6, 5'd6);
    #1;
    check("first_write_rd1", bus.ID_ReadData1, 32'h0000_0066);
    check("first_write_rd2", bus.ID_ReadData2, 32'h0000_0066);

    @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
